default_slave: RTL and testbench
================================

Name: default_slave

Overview:
- Terminates every AXI transaction whose address decodes to no mapped slave.
- Sits directly upstream of the interconnect's read-data and write-response channels as slave SD; drives the `_SD` R and B ports.
- Accepts AR/AW/W handshakes and returns DECERR responses with the original slave-side ID, so the interconnect can route each response back to the issuing master.
- Read and write paths are independent FSMs.

Parameters:
- ID_W, `AXI_IDS_BITS (8): slave-side ID width; upper 4 bits = master ID, lower 4 = original ID.
- DATA_W, `AXI_DATA_BITS (32): R data width.
- LEN_W, `AXI_LEN_BITS (4): burst length field width; beats = LEN+1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ARID_SD  in  ID_W  read request ID
- ARLEN_SD  in  LEN_W  read burst length minus 1
- ARVALID_SD  in  1  read request valid
- ARREADY_SD  out  1  read request ready
- RID_SD  out  ID_W  response ID (latched ARID)
- RDATA_SD  out  DATA_W  read data, always 0
- RRESP_SD  out  2  2'b11 (DECERR) while RVALID
- RLAST_SD  out  1  final beat of burst
- RVALID_SD  out  1  read data valid
- RREADY_SD  in  1  read data ready
- AWID_SD  in  ID_W  write request ID
- AWVALID_SD  in  1  write request valid
- AWREADY_SD  out  1  write request ready
- WLAST_SD  in  1  final write beat
- WVALID_SD  in  1  write data valid
- WREADY_SD  out  1  write data ready
- BID_SD  out  ID_W  write response ID (latched AWID)
- BRESP_SD  out  2  2'b11 (DECERR) while BVALID
- BVALID_SD  out  1  write response valid
- BREADY_SD  in  1  write response ready

Behaviour:
- Reset (rst low, async):
  - Both FSMs go to IDLE.
  - ARREADY=1, AWREADY=1; all other outputs 0 (RVALID, RLAST, WREADY, BVALID, RID, BID, RDATA, RRESP, BRESP).
  - Reset mid-burst aborts with no further beats.
- Read FSM states R_IDLE, R_BURST:
  - R_IDLE: ARREADY=1, RVALID=0. On ARVALID&ARREADY at edge t: latch ARID → rid_q, ARLEN → len_q; clear beat_cnt; go to R_BURST. First RVALID appears at t+1 (1-cycle latency).
  - R_BURST: ARREADY=0, RVALID=1, RDATA=0, RRESP=DECERR, RID=rid_q, RLAST=(beat_cnt==len_q).
  - R_BURST handshake (RVALID&RREADY): beat_cnt+1. If RLAST, return to R_IDLE, with ARREADY=1 in the next cycle. No back-to-back AR acceptance in the same cycle.
  - RREADY low: all R outputs held stable and beat_cnt frozen (AXI stability rule).
  - beat_cnt is LEN_W bits and never wraps: the maximum is len_q=15, giving 16 beats, and the exit happens at 15.
- Write FSM states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID&AWREADY: latch AWID → bid_q; go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Data is discarded. On WVALID&WLAST: go to W_RESP. Beats are not counted; WLAST alone terminates.
  - W_RESP: BVALID=1, BID=bid_q, BRESP=DECERR. On BREADY: go to W_IDLE.
  - W beats presented before the AW handshake are not accepted (WREADY=0 in W_IDLE).
- Simultaneous events:
  - AR and AW in the same cycle are both accepted; the read and write FSMs are fully concurrent.
  - An R handshake on RLAST with ARVALID high in the same cycle does not accept the new AR; it is accepted the next cycle.
- No combinational path from any input to any output; all outputs are registered or decoded from state registers.

Decomposition:
- The shared AXI package/define file holds:
  - ID/DATA/LEN widths
  - RESP encodings OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11
  - FSM state enums for reuse by future slave wrappers
- One natural sub-module: default_slave_rd (read FSM plus beat counter), instantiated once. The write FSM stays inline.

Test Plan:
- Reset release → ARREADY=1, AWREADY=1, RVALID=0, BVALID=0, WREADY=0.
- AR ARID=8'h21 ARLEN=0 with RREADY=1 → one beat one cycle after handshake: RID=8'h21, RDATA=0, RRESP=2'b11, RLAST=1; ARREADY=1 the cycle after.
- AR ARID=8'h13 ARLEN=15 with RREADY toggled 1,0,1,… → exactly 16 handshaked beats; RLAST only on the 16th; outputs stable during RREADY=0.
- AW AWID=8'h32, then 4 W beats with WLAST on the 4th, BREADY held low 3 cycles → BVALID=1, BID=8'h32, BRESP=2'b11 held until BREADY, then W_IDLE.
- AR (ID 8'h05, LEN 3) and AW (ID 8'h16) in the same cycle → both accepted; R burst and B response complete independently with correct IDs.
- rst asserted during beat 2 of an ARLEN=7 burst → RVALID drops immediately; after release, a new AR ID=8'h2A LEN=0 returns a single beat RID=8'h2A.

Source files
------------

// File: rtl/default_slave_pkg.sv
// Shared AXI definitions: bus widths, response codes and slave FSM state types.
package default_slave_pkg;

    localparam int AXI_ID_W   = 8;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

endpackage

// File: rtl/default_slave_rd.sv
// Read side of the default slave: accepts one AR at a time and returns
// LEN+1 DECERR beats carrying the request ID.
module default_slave_rd
    import default_slave_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   i_arid,
    input  logic [LEN_W-1:0]  i_arlen,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [ID_W-1:0]   o_rid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rlast,
    output logic              o_rvalid,
    input  logic              i_rready
);

    rd_state_e        r_state;
    rd_state_e        w_next;
    logic [ID_W-1:0]  r_rid;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_last;

    assign w_ar_hs = (r_state == R_IDLE) && i_arvalid;
    assign w_last  = (r_state == R_BURST) && (r_cnt == r_len);
    assign w_r_hs  = (r_state == R_BURST) && i_rready;

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: leave idle on AR, return only after the last beat is taken.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            R_IDLE:  if (i_arvalid) w_next = R_BURST;
            R_BURST: if (i_rready && w_last) w_next = R_IDLE;
            default: w_next = R_IDLE;
        endcase
    end

    // Request capture and beat counter; the counter stops at the last beat so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rid <= '0;
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_ar_hs) begin
            r_rid <= i_arid;
            r_len <= i_arlen;
            r_cnt <= '0;
        end else if (w_r_hs && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_arready = (r_state == R_IDLE);
    assign o_rvalid  = (r_state == R_BURST);
    assign o_rid     = o_rvalid ? r_rid : '0;
    assign o_rdata   = '0;
    assign o_rresp   = o_rvalid ? RESP_DECERR : RESP_OKAY;
    assign o_rlast   = w_last;

endmodule

// File: rtl/default_slave.sv
// Default AXI slave: terminates unmapped reads and writes with DECERR,
// echoing the slave-side ID so responses route back to the issuing master.
module default_slave
    import default_slave_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID_SD,
    input  logic [LEN_W-1:0]  ARLEN_SD,
    input  logic              ARVALID_SD,
    output logic              ARREADY_SD,
    output logic [ID_W-1:0]   RID_SD,
    output logic [DATA_W-1:0] RDATA_SD,
    output logic [1:0]        RRESP_SD,
    output logic              RLAST_SD,
    output logic              RVALID_SD,
    input  logic              RREADY_SD,
    input  logic [ID_W-1:0]   AWID_SD,
    input  logic              AWVALID_SD,
    output logic              AWREADY_SD,
    input  logic              WLAST_SD,
    input  logic              WVALID_SD,
    output logic              WREADY_SD,
    output logic [ID_W-1:0]   BID_SD,
    output logic [1:0]        BRESP_SD,
    output logic              BVALID_SD,
    input  logic              BREADY_SD
);

    wr_state_e       r_wstate;
    wr_state_e       w_wnext;
    logic [ID_W-1:0] r_bid;

    default_slave_rd #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_rd (
        .clk       (clk),
        .rst       (rst),
        .i_arid    (ARID_SD),
        .i_arlen   (ARLEN_SD),
        .i_arvalid (ARVALID_SD),
        .o_arready (ARREADY_SD),
        .o_rid     (RID_SD),
        .o_rdata   (RDATA_SD),
        .o_rresp   (RRESP_SD),
        .o_rlast   (RLAST_SD),
        .o_rvalid  (RVALID_SD),
        .i_rready  (RREADY_SD)
    );

    // Write state register; runs independently of the read side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    // Write next state: AW, then sink data until WLAST, then hold B until taken.
    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (AWVALID_SD) w_wnext = W_DATA;
            W_DATA:  if (WVALID_SD && WLAST_SD) w_wnext = W_RESP;
            W_RESP:  if (BREADY_SD) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    // Capture the write ID on AW acceptance for the B response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bid <= '0;
        end else if ((r_wstate == W_IDLE) && AWVALID_SD) begin
            r_bid <= AWID_SD;
        end
    end

    assign AWREADY_SD = (r_wstate == W_IDLE);
    assign WREADY_SD  = (r_wstate == W_DATA);
    assign BVALID_SD  = (r_wstate == W_RESP);
    assign BID_SD     = BVALID_SD ? r_bid : '0;
    assign BRESP_SD   = BVALID_SD ? RESP_DECERR : RESP_OKAY;

endmodule

// File: tb/tb_default_slave.sv
// Scoreboard bench for default_slave: drivers queue expected R beats and B
// responses; a negedge monitor checks the DUT against a transaction-level model.
module tb_default_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  ARID_SD;
    logic [3:0]  ARLEN_SD;
    logic        ARVALID_SD;
    logic        ARREADY_SD;
    logic [7:0]  RID_SD;
    logic [31:0] RDATA_SD;
    logic [1:0]  RRESP_SD;
    logic        RLAST_SD;
    logic        RVALID_SD;
    logic        RREADY_SD;
    logic [7:0]  AWID_SD;
    logic        AWVALID_SD;
    logic        AWREADY_SD;
    logic        WLAST_SD;
    logic        WVALID_SD;
    logic        WREADY_SD;
    logic [7:0]  BID_SD;
    logic [1:0]  BRESP_SD;
    logic        BVALID_SD;
    logic        BREADY_SD;

    default_slave dut (
        .clk        (clk),
        .rst        (rst),
        .ARID_SD    (ARID_SD),
        .ARLEN_SD   (ARLEN_SD),
        .ARVALID_SD (ARVALID_SD),
        .ARREADY_SD (ARREADY_SD),
        .RID_SD     (RID_SD),
        .RDATA_SD   (RDATA_SD),
        .RRESP_SD   (RRESP_SD),
        .RLAST_SD   (RLAST_SD),
        .RVALID_SD  (RVALID_SD),
        .RREADY_SD  (RREADY_SD),
        .AWID_SD    (AWID_SD),
        .AWVALID_SD (AWVALID_SD),
        .AWREADY_SD (AWREADY_SD),
        .WLAST_SD   (WLAST_SD),
        .WVALID_SD  (WVALID_SD),
        .WREADY_SD  (WREADY_SD),
        .BID_SD     (BID_SD),
        .BRESP_SD   (BRESP_SD),
        .BVALID_SD  (BVALID_SD),
        .BREADY_SD  (BREADY_SD)
    );

    typedef struct packed {
        logic [7:0] id;
        logic       last;
    } rbeat_t;

    rbeat_t     rq[$];
    logic [7:0] bq[$];

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model: read side busy or not; write side in address,
    // data or response phase (0/1/2).
    bit m_rbusy = 0;
    int m_wph   = 0;

    int rr_mode = 0;   // 0: always ready, 1: toggle, 2: random
    int br_mode = 0;   // 0: always ready, 1: random, 2: manual
    bit br_man  = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ready generators, updated just after each rising edge.
    initial begin
        RREADY_SD = 1;
        BREADY_SD = 1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       RREADY_SD = 1;
                1:       RREADY_SD = ~RREADY_SD;
                default: RREADY_SD = 1'($urandom_range(0, 1));
            endcase
            case (br_mode)
                0:       BREADY_SD = 1;
                1:       BREADY_SD = 1'($urandom_range(0, 1));
                default: BREADY_SD = br_man;
            endcase
        end
    end

    // Monitor: compares DUT outputs against the model on every falling edge.
    initial begin
        rbeat_t exp_b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rq.delete();
                bq.delete();
                m_rbusy = 0;
                m_wph   = 0;
            end else begin
                if (!m_rbusy) begin
                    chk("arready_idle", 32'(ARREADY_SD), 1);
                    chk("rvalid_idle", 32'(RVALID_SD), 0);
                    if (ARVALID_SD) m_rbusy = 1;
                end else begin
                    chk("arready_busy", 32'(ARREADY_SD), 0);
                    chk("rvalid_busy", 32'(RVALID_SD), 1);
                    if (rq.size() == 0) begin
                        chk("r_queue_nonempty", 0, 1);
                    end else begin
                        exp_b = rq[0];
                        chk("rid", 32'(RID_SD), 32'(exp_b.id));
                        chk("rdata", RDATA_SD, 0);
                        chk("rresp", 32'(RRESP_SD), 3);
                        chk("rlast", 32'(RLAST_SD), 32'(exp_b.last));
                        if (RREADY_SD) begin
                            void'(rq.pop_front());
                            if (exp_b.last) m_rbusy = 0;
                        end
                    end
                end
                case (m_wph)
                    0: begin
                        chk("awready_idle", 32'(AWREADY_SD), 1);
                        chk("wready_idle", 32'(WREADY_SD), 0);
                        chk("bvalid_idle", 32'(BVALID_SD), 0);
                        if (AWVALID_SD) m_wph = 1;
                    end
                    1: begin
                        chk("awready_data", 32'(AWREADY_SD), 0);
                        chk("wready_data", 32'(WREADY_SD), 1);
                        chk("bvalid_data", 32'(BVALID_SD), 0);
                        if (WVALID_SD && WLAST_SD) m_wph = 2;
                    end
                    default: begin
                        chk("awready_resp", 32'(AWREADY_SD), 0);
                        chk("wready_resp", 32'(WREADY_SD), 0);
                        chk("bvalid_resp", 32'(BVALID_SD), 1);
                        if (bq.size() == 0) begin
                            chk("b_queue_nonempty", 0, 1);
                        end else begin
                            chk("bid", 32'(BID_SD), 32'(bq[0]));
                            chk("bresp", 32'(BRESP_SD), 3);
                            if (BREADY_SD) begin
                                void'(bq.pop_front());
                                m_wph = 0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic do_read(input logic [7:0] id, input logic [3:0] len);
        bit ok = 0;
        @(posedge clk);
        #1;
        ARID_SD    = id;
        ARLEN_SD   = len;
        ARVALID_SD = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ARREADY_SD) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            for (int b = 0; b <= int'(len); b++) rq.push_back('{id: id, last: (b == int'(len))});
        end else begin
            chk("ar_accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        ARVALID_SD = 0;
    endtask

    task automatic wait_wready(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (WREADY_SD) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] id, input int nbeats, input bit early_w);
        bit ok = 0;
        @(posedge clk);
        #1;
        AWID_SD    = id;
        AWVALID_SD = 1;
        if (early_w) begin
            WVALID_SD = 1;
            WLAST_SD  = (nbeats == 1);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (AWREADY_SD) begin
                ok = 1;
                break;
            end
        end
        if (ok) bq.push_back(id);
        else    chk("aw_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        AWVALID_SD = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (!(early_w && b == 0)) begin
                WVALID_SD = 0;
                WLAST_SD  = 0;
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
                WVALID_SD = 1;
                WLAST_SD  = (b == nbeats - 1);
            end
            wait_wready(ok);
            if (!ok) chk("w_accept_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        WVALID_SD = 0;
        WLAST_SD  = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rq.size() == 0 && bq.size() == 0 && !m_rbusy && m_wph == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, 32'(ARREADY_SD), 1);
        chk({tag, "_awready"}, 32'(AWREADY_SD), 1);
        chk({tag, "_rvalid"}, 32'(RVALID_SD), 0);
        chk({tag, "_rlast"}, 32'(RLAST_SD), 0);
        chk({tag, "_wready"}, 32'(WREADY_SD), 0);
        chk({tag, "_bvalid"}, 32'(BVALID_SD), 0);
        chk({tag, "_rid"}, 32'(RID_SD), 0);
        chk({tag, "_bid"}, 32'(BID_SD), 0);
        chk({tag, "_rdata"}, RDATA_SD, 0);
        chk({tag, "_rresp"}, 32'(RRESP_SD), 0);
        chk({tag, "_bresp"}, 32'(BRESP_SD), 0);
    endtask

    initial begin
        bit ok;
        rst        = 0;
        ARID_SD    = '0;
        ARLEN_SD   = '0;
        ARVALID_SD = 0;
        AWID_SD    = '0;
        AWVALID_SD = 0;
        WVALID_SD  = 0;
        WLAST_SD   = 0;

        // Reset state, then release away from the clock edge.
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk_reset_outputs("released");

        // Single-beat read.
        rr_mode = 0;
        do_read(8'h21, 4'd0);
        wait_idle();

        // 16-beat read with RREADY toggling.
        rr_mode = 1;
        do_read(8'h13, 4'd15);
        wait_idle();
        rr_mode = 0;

        // Write with W presented before AW is taken, B held off for 3 cycles.
        br_mode = 2;
        br_man  = 0;
        do_write(8'h32, 4, 1'b1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (BVALID_SD) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("bvalid_timeout", 0, 1);
        repeat (3) @(negedge clk);
        br_man = 1;
        wait_idle();
        br_mode = 0;

        // Concurrent AR and AW in the same cycle.
        fork
            do_read(8'h05, 4'd3);
            do_write(8'h16, 2, 1'b0);
        join
        wait_idle();

        // Reset in the middle of an 8-beat read, during beat 2.
        do_read(8'h44, 4'd7);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rq.size() == 6) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("mid_burst_timeout", 0, 1);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk_reset_outputs("midburst_reset");
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1;
        do_read(8'h2A, 4'd0);
        wait_idle();

        // Randomized mix of reads, writes and concurrent pairs.
        for (int t = 0; t < 16; t++) begin
            int sel;
            logic [7:0] rid;
            logic [7:0] wid;
            logic [3:0] len;
            int nb;
            rr_mode = $urandom_range(0, 2);
            br_mode = $urandom_range(0, 1);
            sel = $urandom_range(0, 2);
            rid = 8'($urandom);
            wid = 8'($urandom);
            len = 4'($urandom);
            nb  = $urandom_range(1, 5);
            case (sel)
                0: do_read(rid, len);
                1: do_write(wid, nb, 1'($urandom_range(0, 1)));
                default: fork
                    do_read(rid, len);
                    do_write(wid, nb, 1'b0);
                join
            endcase
            wait_idle();
        end
        rr_mode = 0;
        br_mode = 0;

        chk("final_rq_empty", rq.size(), 0);
        chk("final_bq_empty", bq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
